// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants for the 5x5 convolution datapath
package conv_pkg;
    localparam int KERNEL    = 5;
    localparam int PIX_W     = 8;
    localparam int SEL_W     = 3;
    localparam int NUM_LINES = KERNEL - 1;

    // Physical line holding the line that is `age` lines younger than the one at `base`
    function automatic logic [1:0] line_idx(input logic [1:0] base, input int unsigned age);
        return base + age[1:0];
    endfunction
endpackage

// File: rtl/conv_line_mem.sv
// rtl/conv_line_mem.sv - one buffered image line, sync write / async read
module conv_line_mem #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/conv_row_feeder.sv
// rtl/conv_row_feeder.sv - raster stream to 5-tall pixel columns for the kernel array
module conv_row_feeder
    import conv_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int PIX_W = conv_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] R1,
    output logic [PIX_W-1:0] R2,
    output logic [PIX_W-1:0] R3,
    output logic [PIX_W-1:0] R4,
    output logic [PIX_W-1:0] R5,
    output logic [SEL_W-1:0] sel,
    output logic             out_sol,
    output logic             out_eol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       wr_line_q, wr_line_d;
    logic [2:0]       phase_q, phase_d;
    logic [PIX_W-1:0] tap_q [KERNEL];
    logic [PIX_W-1:0] tap_d [KERNEL];
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sol_q, sol_d, eol_q, eol_d;
    logic             valid_q, valid_d, done_q, done_d;
    logic [PIX_W-1:0] line_rd [NUM_LINES];
    logic             accept, col_last, row_last;

    assign in_ready = !flush && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign col_last = (col_q == COL_W'(IMG_W - 1));
    assign row_last = (row_q == ROW_W'(IMG_H - 1));

    // The line addressed by wr_line is read (oldest data) before being overwritten
    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        conv_line_mem #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line (
            .clk   (clk),
            .we    (accept && (wr_line_q == 2'(g))),
            .waddr (col_q),
            .wdata (in_pix),
            .raddr (col_q),
            .rdata (line_rd[g])
        );
    end

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        wr_line_d = wr_line_q;
        phase_d   = phase_q;
        tap_d     = tap_q;
        sel_d     = sel_q;
        sol_d     = sol_q;
        eol_d     = eol_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        if (flush) begin
            col_d     = '0;
            row_d     = '0;
            wr_line_d = '0;
            phase_d   = '0;
            valid_d   = 1'b0;
        end else if (accept) begin
            for (int k = 0; k < NUM_LINES; k++) begin
                tap_d[k] = line_rd[line_idx(wr_line_q, k)];
            end
            tap_d[NUM_LINES] = in_pix;
            sel_d   = SEL_W'(phase_q);
            sol_d   = (col_q == '0);
            eol_d   = col_last;
            valid_d = (row_q >= ROW_W'(NUM_LINES));
            if (col_last) begin
                col_d     = '0;
                phase_d   = '0;
                wr_line_d = wr_line_q + 2'd1;
                if (row_last) begin
                    row_d  = '0;
                    done_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d   = col_q + 1'b1;
                phase_d = (phase_q == 3'(KERNEL - 1)) ? 3'd0 : phase_q + 3'd1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q     <= '0;
            row_q     <= '0;
            wr_line_q <= '0;
            phase_q   <= '0;
            tap_q     <= '{default: '0};
            sel_q     <= '0;
            sol_q     <= 1'b0;
            eol_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            wr_line_q <= wr_line_d;
            phase_q   <= phase_d;
            tap_q     <= tap_d;
            sel_q     <= sel_d;
            sol_q     <= sol_d;
            eol_q     <= eol_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign R1         = tap_q[0];
    assign R2         = tap_q[1];
    assign R3         = tap_q[2];
    assign R4         = tap_q[3];
    assign R5         = tap_q[4];
    assign sel        = sel_q;
    assign out_sol    = sol_q;
    assign out_eol    = eol_q;
    assign out_valid  = valid_q;
    assign frame_done = done_q;
endmodule
